// File: rtl/sr_drv_pkg.sv
// Shared types and helpers for the SR latch command driver: FSM state
// encodings and the timer width calculation.
package sr_drv_pkg;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_PULSE_ENC = 2'd1;
    localparam logic [1:0] ST_GAP_ENC   = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ST_IDLE_ENC,
        PULSE = ST_PULSE_ENC,
        GAP   = ST_GAP_ENC
    } sr_drv_state_t;

    function automatic int cnt_width(input int pulse_w, input int gap_w);
        int m;
        m = (pulse_w > gap_w) ? pulse_w : gap_w;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter shared by the PULSE and GAP phases; done marks the
// final cycle of the loaded interval and the count never wraps below zero.
module sr_pulse_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_run,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_run && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done = (r_cnt <= CNT_W'(1));

endmodule

// File: rtl/sr_latch_driver.sv
// Converts set/clear commands into timed s/r + enable pulses with dead time.
// Optional latch feedback checker enabled by defining SR_LATCH_FB_CHECK_EN.
module sr_latch_driver
    import sr_drv_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic s,
    output logic r,
    output logic enable,
    output logic q_model,
    output logic busy
`ifdef SR_LATCH_FB_CHECK_EN
    ,
    input  logic q_fb,
    input  logic qb_fb,
    output logic fb_err
`endif
);

    localparam int CNT_W = cnt_width(PULSE_W, GAP_W);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W);
    localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_W);

    sr_drv_state_t    r_state;
    logic             r_cap;
    logic             r_s;
    logic             r_r;
    logic             r_en;
    logic             r_q;
    logic             r_busy;
    logic             r_ready;
    logic             w_load;
    logic [CNT_W-1:0] w_load_val;
    logic             w_run;
    logic             w_done;

    always_comb begin
        w_load     = 1'b0;
        w_load_val = PULSE_LD;
        case (r_state)
            IDLE: begin
                if (cmd_valid && (cmd_set != r_q)) begin
                    w_load = 1'b1;
                end
            end
            PULSE: begin
                if (w_done && (GAP_W != 0)) begin
                    w_load     = 1'b1;
                    w_load_val = GAP_LD;
                end
            end
            default: ;
        endcase
    end

    assign w_run = (r_state != IDLE);

    sr_pulse_timer #(.CNT_W(CNT_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .i_run      (w_run),
        .o_done     (w_done)
    );

    // s and r are only ever written as a complementary pair or both low.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_cap   <= 1'b0;
            r_s     <= 1'b0;
            r_r     <= 1'b0;
            r_en    <= 1'b0;
            r_q     <= 1'b0;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (cmd_valid && (cmd_set != r_q)) begin
                        r_cap   <= cmd_set;
                        r_s     <= cmd_set;
                        r_r     <= ~cmd_set;
                        r_en    <= 1'b1;
                        r_busy  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= PULSE;
                    end
                end
                PULSE: begin
                    if (w_done) begin
                        r_q  <= r_cap;
                        r_s  <= 1'b0;
                        r_r  <= 1'b0;
                        r_en <= 1'b0;
                        if (GAP_W == 0) begin
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                            r_state <= IDLE;
                        end else begin
                            r_state <= GAP;
                        end
                    end
                end
                GAP: begin
                    if (w_done) begin
                        r_busy  <= 1'b0;
                        r_ready <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_s     <= 1'b0;
                    r_r     <= 1'b0;
                    r_en    <= 1'b0;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign cmd_ready = r_ready;
    assign s         = r_s;
    assign r         = r_r;
    assign enable    = r_en;
    assign q_model   = r_q;
    assign busy      = r_busy;

`ifdef SR_LATCH_FB_CHECK_EN
    logic r_fb_pulsed;
    logic r_fb_idle_d;
    logic r_fb_err;

    // Feedback is compared only from the second IDLE cycle after a pulse,
    // giving the latch a cycle to settle after enable drops.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fb_pulsed <= 1'b0;
            r_fb_idle_d <= 1'b0;
            r_fb_err    <= 1'b0;
        end else begin
            r_fb_idle_d <= (r_state == IDLE);
            if (r_state != IDLE) begin
                r_fb_pulsed <= 1'b1;
            end
            if ((r_state == IDLE) && r_fb_idle_d && r_fb_pulsed &&
                ((q_fb != r_q) || (qb_fb != ~r_q))) begin
                r_fb_err <= 1'b1;
            end
        end
    end

    assign fb_err = r_fb_err;
`endif

endmodule

// File: tb/tb_sr_latch_driver.sv
// Scoreboard bench for sr_latch_driver: the driver pushes expected pulses,
// an independent monitor pops and checks them against the DUT outputs.
module tb_sr_latch_driver;

    localparam int P = 2;
    localparam int G = 1;

    typedef struct {
        logic v;
        logic prev;
        int   acc_edge;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic cmd_valid = 1'b0;
    logic cmd_set = 1'b0;
    logic cmd_ready, s, r, enable, q_model, busy;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    logic q_ref = 1'b0;
    exp_t exp_q[$];

    exp_t cur;
    bit   in_pulse = 0;
    int   run = 0;

    sr_latch_driver #(.PULSE_W(P), .GAP_W(G)) dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_set   (cmd_set),
        .cmd_ready (cmd_ready),
        .s         (s),
        .r         (r),
        .enable    (enable),
        .q_model   (q_model),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: samples just after each rising edge, independent of stimulus.
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            in_pulse = 0;
            run = 0;
        end else begin
            chk("s_and_r_exclusive", int'(s & r), 0);
            if (enable) begin
                if (!in_pulse) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_pulse", 1, 0);
                    end else begin
                        cur = exp_q.pop_front();
                        in_pulse = 1;
                        run = 0;
                        chk("pulse_start_cycle", cyc, cur.acc_edge);
                    end
                end
                if (in_pulse) begin
                    run++;
                    chk("s_drive", int'(s), int'(cur.v));
                    chk("r_drive", int'(r), int'(!cur.v));
                    chk("q_model_hold", int'(q_model), int'(cur.prev));
                    chk("busy_in_pulse", int'(busy), 1);
                end
            end else begin
                chk("drive_low_outside_pulse", int'({s, r}), 0);
                if (in_pulse) begin
                    chk("pulse_length", run, P);
                    chk("q_model_update", int'(q_model), int'(cur.v));
                    in_pulse = 0;
                end
            end
        end
    end

    task automatic idle(input int n);
        if (n > 0) begin
            cmd_valid = 1'b0;
            repeat (n) @(negedge clk);
        end
    endtask

    // Called at a falling edge; returns once the command has been handled.
    task automatic issue(input logic v, output int acc);
        int  w;
        bit  nonred;
        w = 0;
        acc = -1;
        cmd_valid = 1'b1;
        cmd_set = v;
        while (!cmd_ready && w < 64) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("accept_timeout", 0, 1);
            cmd_valid = 1'b0;
            return;
        end
        acc = cyc + 1;
        nonred = (v != q_ref);
        if (nonred) begin
            exp_q.push_back('{v, q_ref, acc});
            q_ref = v;
        end
        @(negedge clk);
        if (nonred) begin
            chk("busy_after_accept", int'(busy), 1);
            chk("ready_low_after_accept", int'(cmd_ready), 0);
            w = 0;
            while (!cmd_ready && w < 64) begin
                @(negedge clk);
                w++;
            end
            chk("ready_return_latency", cyc - acc, P + G);
        end else begin
            chk("redundant_ready_high", int'(cmd_ready), 1);
            chk("redundant_not_busy", int'(busy), 0);
            chk("redundant_q_unchanged", int'(q_model), int'(q_ref));
        end
    endtask

    initial begin
        int acc;
        int prev_acc;
        int tmp;

        repeat (3) @(negedge clk);
        reset = 1'b0;

        repeat (5) begin
            @(negedge clk);
            chk("rst_s", int'(s), 0);
            chk("rst_r", int'(r), 0);
            chk("rst_enable", int'(enable), 0);
            chk("rst_ready", int'(cmd_ready), 1);
            chk("rst_q_model", int'(q_model), 0);
            chk("rst_busy", int'(busy), 0);
        end

        issue(1'b1, acc);
        issue(1'b1, acc);
        issue(1'b0, acc);
        idle(2);

        prev_acc = 0;
        for (int i = 0; i < 20; i++) begin
            issue(~q_ref, acc);
            if (i > 0) chk("back_to_back_throughput", acc - prev_acc, 1 + P + G);
            prev_acc = acc;
        end

        idle(2);
        cmd_valid = 1'b1;
        cmd_set = ~q_ref;
        chk("abort_cmd_ready", int'(cmd_ready), 1);
        exp_q.push_back('{cmd_set, q_ref, cyc + 1});
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_pulse", int'(enable), 1);
        reset = 1'b1;
        cmd_valid = 1'b0;
        exp_q.delete();
        q_ref = 1'b0;
        @(negedge clk);
        chk("abort_s", int'(s), 0);
        chk("abort_r", int'(r), 0);
        chk("abort_enable", int'(enable), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_q_model", int'(q_model), 0);
        chk("abort_ready", int'(cmd_ready), 1);
        reset = 1'b0;
        tmp = cyc;
        issue(1'b1, acc);
        chk("accept_right_after_reset", acc, tmp + 1);

        for (int i = 0; i < 40; i++) begin
            idle($urandom_range(0, 3));
            issue(1'($urandom_range(0, 1)), acc);
        end

        idle(P + G + 3);
        chk("scoreboard_drained", exp_q.size(), 0);
        chk("final_q_model", int'(q_model), int'(q_ref));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded its time limit at cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
